scan_sel_gen: RTL
=================

Name: scan_sel_gen

Overview:
- Drives the select inputs and the four held 4-bit data words of the 4:1 nibble selector in the display path.
- Time-multiplexes one 7-segment driver across four digits: cycles select 00→01→10→11 at a programmable dwell rate and asserts the matching active-low digit enable.
- Double-buffers new display data so that data updates only take effect at frame boundaries, which prevents digit tearing.

Parameters:
- DIV_WIDTH, 16, width of dwell counter.
- DIV_MAX, 49999, dwell length per digit minus 1, in clock cycles; must fit in DIV_WIDTH and be ≥1.

Ports:
- iClk  input  1  system clock; all logic on rising edge.
- iRst  input  1  synchronous active-high reset.
- iEn  input  1  scan enable; 0 = blank display and hold scan at digit 0.
- iLoad  input  1  one-cycle strobe; captures iD0..iD3 into the shadow buffer.
- iD0  input  4  new digit 0 value (least significant digit).
- iD1  input  4  new digit 1 value.
- iD2  input  4  new digit 2 value.
- iD3  input  4  new digit 3 value (most significant digit).
- oC0  output  4  active digit 0 word, feeds selector iC0.
- oC1  output  4  active digit 1 word, feeds selector iC1.
- oC2  output  4  active digit 2 word, feeds selector iC2.
- oC3  output  4  active digit 3 word, feeds selector iC3.
- oS1  output  1  select MSB, feeds selector iS1.
- oS0  output  1  select LSB, feeds selector iS0.
- oAn  output  4  active-low digit enables; bit k low = digit k lit.
- oPending  output  1  shadow buffer holds data not yet applied.

Behaviour:
- All outputs are registered. Reset (iRst=1 at a clock edge):
  - cnt=0, sel=0, state=IDLE.
  - oC0..oC3=0, shadow=0, oPending=0.
  - oS1/oS0=0, oAn=4'b1111.
- States:
  - IDLE: oAn=1111, cnt=0, sel=0.
  - SCAN: active scanning.
- Transitions:
  - IDLE→SCAN when iEn=1. On the first SCAN cycle, sel=0 and oAn=1110.
  - SCAN→IDLE on the edge where iEn=0, even mid-dwell. Next cycle: cnt=0, sel=0, oAn=1111.
- Dwell counting in SCAN:
  - cnt increments each cycle.
  - When cnt==DIV_MAX: cnt wraps to 0 and sel increments mod 4 (11→00).
  - Each digit stays lit for exactly DIV_MAX+1 cycles.
- Output mapping: {oS1,oS0}=sel. oAn=~(4'b0001<<sel) in SCAN. oAn and sel update on the same edge, so there is no one-cycle mismatch.
- Frame boundary: SCAN with sel==3 and cnt==DIV_MAX.
- Load handshake:
  - iLoad=1 on an edge: shadow←{iD3..iD0} and oPending←1.
  - Repeated loads before a boundary overwrite shadow; the last load wins.
  - At a frame boundary with oPending=1: oC*←shadow and oPending←0.
  - In IDLE with oPending=1: transfer on the next edge, because the display is blank.
- Simultaneous iLoad and frame boundary: oC*←iD* directly, shadow←iD*, oPending=0.
- Simultaneous iLoad and iRst: reset wins, and the load is discarded.
- oC* never change except at a frame boundary, in IDLE, or on reset.

Optional Feature:
- Macro: SCAN_BLANK_LZ_EN (leading-zero blanking).
- Defined:
  - In SCAN, digit k's oAn bit is forced to 1 when oC_k==0 and every higher digit is also 0.
  - Digit 0 is never blanked.
  - Example: oC3..oC0=0,0,7,0 blanks digits 3 and 2; digits 1 and 0 are shown.
  - sel timing is unchanged; blanked digits still consume their dwell.
- Undefined: oAn is always ~(1<<sel) in SCAN.

Test Plan:
- DIV_MAX=3: reset, then iEn=1 → oAn sequence 1110×4 cycles, 1101×4, 1011×4, 0111×4, then back to 1110; {oS1,oS0} tracks 00,01,10,11.
- iLoad with iD3..iD0=9,8,7,6 at sel=1 → oPending=1, oC* unchanged until the cycle after sel=3/cnt=3; then oC3..oC0=9,8,7,6 and oPending=0.
- Two loads (1,2,3,4) then (5,6,7,8) in one frame → only 5,6,7,8 is applied at the boundary.
- iLoad exactly on the boundary cycle → oC* takes the new value on that edge and oPending stays 0.
- iEn dropped at sel=2, cnt=1 → next cycle oAn=1111, sel=0; a pending load applies on the following edge. Re-enabling starts at sel=0, cnt=0.
- iRst mid-SCAN with oPending=1 → all outputs at reset values next cycle. With SCAN_BLANK_LZ_EN defined, oC=0,0,0,5 lights only digit 0 (oAn=1110 in slot 0, 1111 in slots 1–3).

Source files
------------

// File: rtl/scan_sel_gen.sv
// scan_sel_gen: digit scan and display-data double buffer for a four-digit
// 7-segment display sharing one segment driver.
//
// Walks the nibble-selector select lines 00->01->10->11, holding each digit
// for DIV_MAX+1 clocks, and drives the matching active-low digit enable.
// New display words are captured into a shadow buffer and only copied to the
// active words at the end of a full frame (or at once while the display is
// blank), so a digit never shows a mix of old and new data.
//
// Optional build macro SCAN_BLANK_LZ_EN: leading-zero blanking. Digits whose
// active word is zero, and whose higher digits are all zero too, are kept
// dark. Digit 0 is always shown. Scan timing is unaffected.
//
// state | meaning
// IDLE  | display blank (oAn=1111), dwell counter and select parked at 0
// SCAN  | digits lit in turn, dwell counter running

module scan_sel_gen #(
   parameter int DIV_WIDTH = 16,
   parameter int DIV_MAX   = 49999
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iEn,
   input  logic       iLoad,
   input  logic [3:0] iD0,
   input  logic [3:0] iD1,
   input  logic [3:0] iD2,
   input  logic [3:0] iD3,
   output logic [3:0] oC0,
   output logic [3:0] oC1,
   output logic [3:0] oC2,
   output logic [3:0] oC3,
   output logic       oS1,
   output logic       oS0,
   output logic [3:0] oAn,
   output logic       oPending
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   localparam logic [DIV_WIDTH-1:0] CNT_MAX = DIV_WIDTH'(DIV_MAX);
   localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]           sel_q, sel_d;
   logic [15:0]          act_q, act_d;
   logic [15:0]          shadow_q, shadow_d;
   logic                 pend_q, pend_d;
   logic [3:0]           an_q, an_d;

   logic                 frame_end;
   logic                 xfer;
   logic [15:0]          new_word;
   logic [3:0]           lit;

   assign new_word  = {iD3, iD2, iD1, iD0};
   assign frame_end = (state_q == ST_SCAN) && (sel_q == 2'd3) && (cnt_q == CNT_MAX);
   assign xfer      = pend_q && (frame_end || (state_q == ST_IDLE));

   // Scan sequencing: enter SCAN at digit 0, advance select every DIV_MAX+1 clocks, park on disable.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      if (!iEn) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         sel_d   = 2'd0;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_SCAN;
         cnt_d   = '0;
         sel_d   = 2'd0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         sel_d = sel_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Double buffer: a load on the frame-end edge goes straight through, otherwise it waits in the shadow.
   always_comb begin
      act_d    = act_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      if (iLoad && frame_end) begin
         act_d    = new_word;
         shadow_d = new_word;
         pend_d   = 1'b0;
      end else begin
         if (xfer) begin
            act_d  = shadow_q;
            pend_d = 1'b0;
         end
         if (iLoad) begin
            shadow_d = new_word;
            pend_d   = 1'b1;
         end
      end
   end

   // Digit visibility mask, evaluated on the words that will be active next cycle.
   always_comb begin
`ifdef SCAN_BLANK_LZ_EN
      lit[3] = (act_d[15:12] != 4'd0);
      lit[2] = lit[3] || (act_d[11:8] != 4'd0);
      lit[1] = lit[2] || (act_d[7:4] != 4'd0);
      lit[0] = 1'b1;
`else
      lit = 4'hF;
`endif
   end

   // Digit enable tracks the next select value so oAn and {oS1,oS0} change on the same edge.
   always_comb begin
      an_d = 4'hF;
      if (state_d == ST_SCAN) begin
         an_d = ~((4'b0001 << sel_d) & lit);
      end
   end

   // State and output registers with synchronous reset; reset drops any load on the same edge.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sel_q    <= 2'd0;
         act_q    <= '0;
         shadow_q <= '0;
         pend_q   <= 1'b0;
         an_q     <= 4'hF;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         act_q    <= act_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         an_q     <= an_d;
      end
   end

   assign oC0      = act_q[3:0];
   assign oC1      = act_q[7:4];
   assign oC2      = act_q[11:8];
   assign oC3      = act_q[15:12];
   assign oS1      = sel_q[1];
   assign oS0      = sel_q[0];
   assign oAn      = an_q;
   assign oPending = pend_q;

endmodule
